cpu_controller: RTL and testbench

Instruction sequencer for the 8-bit CPU datapath. It drives the load, increment, select, read and write strobes of the datapath registers (accumulator, instruction register, program counter), memory and bus driver. It steps an 8-phase cycle per instruction and decodes the 3-bit opcode from the instruction register and the accumulator zero flag. Halting is sticky until reset.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/cpu_controller_if.sv | 27 ++
 rtl/cpu_controller_phase_counter.sv | 18 +
 rtl/cpu_controller.sv | 89 ++++++++
 tb/tb_cpu_controller.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU: opcodes, instruction phases and a
// packed strobe bundle used by the controller decode.
package cpu_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam int NUM_PHASES = 8;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic ld_ac;
        logic wr;
        logic data_e;
        logic halt;
    } strobes_t;

    // Opcodes whose operand is read from memory and written into the accumulator.
    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Controller-to-datapath bundle: decoded instruction inputs and register/memory strobes.
interface cpu_controller_if;
    import cpu_pkg::*;

    opcode_t opcode;
    logic    zero;
    logic    sel;
    logic    rd;
    logic    ld_ir;
    logic    inc_pc;
    logic    ld_pc;
    logic    ld_ac;
    logic    wr;
    logic    data_e;
    logic    halt;

    modport master (
        input  opcode, zero,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt
    );

    modport slave (
        output opcode, zero,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt
    );

endinterface

// File: rtl/cpu_controller_phase_counter.sv
// Three-bit instruction phase counter; wraps STORE -> INST_ADDR, freezes on hold.
module phase_counter
    import cpu_pkg::*;
(
    input  logic   CLK,
    input  logic   RST,
    input  logic   hold,
    output phase_t phase
);

    always_ff @(posedge CLK) begin
        if (!RST)
            phase <= INST_ADDR;
        else if (!hold)
            phase <= phase_t'(phase + 3'd1);
    end

endmodule

// File: rtl/cpu_controller.sv
// Instruction sequencer: steps eight phases per instruction and decodes the
// datapath strobes from phase, opcode and the accumulator zero flag.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    cpu_controller_if.master  bus
);

    phase_t   phase;
    logic     halted;
    logic     halt_now;
    logic     aluop;
    strobes_t s;

    // Halt takes effect in the same cycle the HLT opcode reaches OP_ADDR, so
    // the phase never advances past it and the PC is never bumped.
    assign halt_now = halted || (phase == OP_ADDR && bus.opcode == HLT);
    assign aluop    = is_aluop(bus.opcode);

    always_ff @(posedge CLK) begin
        if (!RST)
            halted <= 1'b0;
        else if (phase == OP_ADDR && bus.opcode == HLT)
            halted <= 1'b1;
    end

    phase_counter u_phase (
        .CLK   (CLK),
        .RST   (RST),
        .hold  (halt_now),
        .phase (phase)
    );

    always_comb begin
        s = '0;
        if (halt_now) begin
            s.halt = 1'b1;
        end else begin
            unique case (phase)
                INST_ADDR: begin
                    s.sel = 1'b1;
                end
                INST_FETCH: begin
                    s.sel = 1'b1;
                    s.rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    s.sel   = 1'b1;
                    s.rd    = 1'b1;
                    s.ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    s.inc_pc = 1'b1;
                end
                OP_FETCH: begin
                    s.rd = aluop;
                end
                ALU_OP: begin
                    s.rd     = aluop;
                    s.inc_pc = (bus.opcode == SKZ) && bus.zero;
                    s.ld_pc  = (bus.opcode == JMP);
                    s.data_e = (bus.opcode == STO);
                end
                STORE: begin
                    s.rd     = aluop;
                    s.inc_pc = (bus.opcode == JMP);
                    s.ld_pc  = (bus.opcode == JMP);
                    s.ld_ac  = aluop;
                    s.wr     = (bus.opcode == STO);
                    s.data_e = (bus.opcode == STO);
                end
                default: s = '0;
            endcase
        end
    end

    assign bus.sel    = s.sel;
    assign bus.rd     = s.rd;
    assign bus.ld_ir  = s.ld_ir;
    assign bus.inc_pc = s.inc_pc;
    assign bus.ld_pc  = s.ld_pc;
    assign bus.ld_ac  = s.ld_ac;
    assign bus.wr     = s.wr;
    assign bus.data_e = s.data_e;
    assign bus.halt   = s.halt;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed scenarios plus randomized
// instruction streams against a phase/halt reference model.
module tb_cpu_controller;
    import cpu_pkg::*;

    logic CLK = 1'b0;
    logic RST;

    cpu_controller_if bus();

    cpu_controller dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;

    // Reference model state
    int m_ph  = 0;
    bit m_hl  = 1'b0;
    bit m_ok  = 1'b0;   // model phase known (after first reset edge)

    logic [8:0] got;    // {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}

    function automatic logic [8:0] model_out(int ph, bit hl, int op, bit z);
        logic [8:0] o;
        bit alu;
        bit h;
        o   = '0;
        alu = (op >= 2 && op <= 5);
        h   = hl || (ph == 4 && op == 0);
        if (h) begin
            o[0] = 1'b1;
            return o;
        end
        o[8] = (ph < 4);
        o[7] = (ph >= 1 && ph <= 3) || (alu && ph >= 5);
        o[6] = (ph == 2 || ph == 3);
        o[5] = (ph == 4) || (ph == 6 && op == 1 && z) || (ph == 7 && op == 7);
        o[4] = (op == 7 && ph >= 6);
        o[3] = (alu && ph == 7);
        o[2] = (op == 6 && ph == 7);
        o[1] = (op == 6 && ph >= 6);
        return o;
    endfunction

    // One clock: drive inputs after negedge, compare against the model, then
    // advance the model across the rising edge.
    task automatic step(input bit rst, input int op, input bit z, input string tag);
        logic [8:0] exp;
        @(negedge CLK);
        RST        = rst;
        bus.opcode = opcode_t'(op[2:0]);
        bus.zero   = z;
        #2;
        got = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
               bus.ld_ac, bus.wr, bus.data_e, bus.halt};
        if (m_ok) begin
            exp = model_out(m_ph, m_hl, op, z);
            checks++;
            if (got !== exp)
                $display("FAIL %s phase=%0d op=%0d z=%0b: got %b expected %b",
                         tag, m_ph, op, z, got, exp);
            else
                passes++;
        end
        @(posedge CLK);
        if (!rst) begin
            m_ph = 0;
            m_hl = 1'b0;
            m_ok = 1'b1;
        end else begin
            if (m_ph == 4 && op == 0) m_hl = 1'b1;
            if (!m_hl) m_ph = (m_ph + 1) % 8;
        end
    endtask

    task automatic do_reset(input int op);
        step(1'b0, op, 1'b0, "reset");
    endtask

    task automatic test_reset();
        step(1'b0, 2, 1'b0, "reset1");
        step(1'b0, 2, 1'b0, "reset2");
        step(1'b1, 2, 1'b0, "reset_release");
        checks++;
        if (got !== 9'b1_0000_0000)
            $display("FAIL reset_outputs: got %b expected %b", got, 9'b1_0000_0000);
        else
            passes++;
        for (int p = 1; p < 8; p++) step(1'b1, 2, 1'b0, "walk");
        step(1'b1, 2, 1'b0, "wrap");
        checks++;
        if (got[8] !== 1'b1 || got[6] !== 1'b0 || got[7] !== 1'b0)
            $display("FAIL wrap_phase0: got %b expected sel=1 rd=0 ld_ir=0", got);
        else
            passes++;
    endtask

    task automatic test_add();
        logic [7:0] rd_exp;
        rd_exp = 8'hEE;
        do_reset(2);
        for (int p = 0; p < 8; p++) begin
            step(1'b1, 2, 1'b0, "add");
            checks++;
            if (got[7] !== rd_exp[p] || got[6] !== (p == 2 || p == 3) ||
                got[5] !== (p == 4) || got[3] !== (p == 7) ||
                got[2] !== 1'b0 || got[1] !== 1'b0)
                $display("FAIL add_pattern p=%0d: got %b", p, got);
            else
                passes++;
        end
    endtask

    task automatic test_sto();
        do_reset(6);
        for (int p = 0; p < 8; p++) begin
            step(1'b1, 6, 1'b1, "sto");
            if (p >= 5) begin
                checks++;
                if (got[7] !== 1'b0 || got[1] !== (p >= 6) ||
                    got[2] !== (p == 7) || got[3] !== 1'b0)
                    $display("FAIL sto_pattern p=%0d: got %b", p, got);
                else
                    passes++;
            end
        end
    endtask

    task automatic test_skz();
        for (int zz = 0; zz < 2; zz++) begin
            do_reset(1);
            for (int p = 0; p < 8; p++) begin
                step(1'b1, 1, zz[0], "skz");
                checks++;
                if (got[5] !== ((p == 4) || (p == 6 && zz == 1)))
                    $display("FAIL skz_inc z=%0d p=%0d: got inc_pc=%b", zz, p, got[5]);
                else
                    passes++;
            end
        end
    endtask

    task automatic test_jmp();
        do_reset(7);
        for (int p = 0; p < 8; p++) begin
            step(1'b1, 7, 1'b0, "jmp");
            checks++;
            if (got[4] !== (p >= 6) || got[5] !== (p == 4 || p == 7))
                $display("FAIL jmp_pattern p=%0d: got ld_pc=%b inc_pc=%b",
                         p, got[4], got[5]);
            else
                passes++;
        end
    endtask

    task automatic test_hlt();
        do_reset(0);
        for (int p = 0; p < 4; p++) step(1'b1, 0, 1'b0, "hlt_fetch");
        for (int i = 0; i < 22; i++) begin
            step(1'b1, 0, 1'b0, "hlt_hold");
            checks++;
            if (got !== 9'b0_0000_0001)
                $display("FAIL hlt_frozen cycle=%0d: got %b expected %b",
                         i, got, 9'b0_0000_0001);
            else
                passes++;
        end
        // Opcode changing while halted must not release the halt.
        step(1'b1, 2, 1'b0, "hlt_sticky");
        checks++;
        if (got[0] !== 1'b1)
            $display("FAIL hlt_sticky: got halt=%b expected 1", got[0]);
        else
            passes++;
        do_reset(2);
        step(1'b1, 2, 1'b0, "hlt_after_reset");
        checks++;
        if (got !== 9'b1_0000_0000)
            $display("FAIL hlt_cleared: got %b expected %b", got, 9'b1_0000_0000);
        else
            passes++;
        for (int p = 1; p < 8; p++) step(1'b1, 2, 1'b0, "post_hlt_fetch");
    endtask

    task automatic test_reset_mid();
        bit saw_ld_ac;
        saw_ld_ac = 1'b0;
        do_reset(2);
        for (int p = 0; p < 6; p++) begin
            step(1'b1, 2, 1'b0, "mid_add");
            saw_ld_ac |= got[3];
        end
        step(1'b0, 2, 1'b0, "mid_reset");
        saw_ld_ac |= got[3];
        step(1'b1, 2, 1'b0, "mid_after");
        saw_ld_ac |= got[3];
        checks++;
        if (saw_ld_ac !== 1'b0 || got !== 9'b1_0000_0000)
            $display("FAIL reset_mid: ld_ac_seen=%b outputs=%b expected 0 and %b",
                     saw_ld_ac, got, 9'b1_0000_0000);
        else
            passes++;
    endtask

    task automatic test_random();
        int op;
        bit z;
        bit rst;
        op = 2;
        z  = 1'b0;
        do_reset(op);
        for (int i = 0; i < 600; i++) begin
            // Datapath holds opcode/zero stable from INST_LOAD through STORE.
            if (m_ph < 2) begin
                op = $urandom_range(0, 7);
                z  = $urandom_range(0, 1);
            end
            rst = ($urandom_range(0, 39) != 0);
            step(rst, op, z, "random");
        end
    endtask

    initial begin
        RST        = 1'b0;
        bus.opcode = ADD;
        bus.zero   = 1'b0;
        test_reset();
        test_add();
        test_sto();
        test_skz();
        test_jmp();
        test_hlt();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
